// File: rtl/apb3_timer_pkg.sv
// Shared constants for the APB3 timer: register byte offsets and CTRL bit
// positions. Offsets are full 32-bit byte addresses with bits [1:0] clear so
// they compare directly against the word-aligned, zero-extended PADDR.
package apb3_timer_pkg;

  localparam logic [31:0] OFS_LOAD     = 32'h00;
  localparam logic [31:0] OFS_VALUE    = 32'h04;
  localparam logic [31:0] OFS_CTRL     = 32'h08;
  localparam logic [31:0] OFS_PRESCALE = 32'h0C;
  localparam logic [31:0] OFS_INTCLR   = 32'h10;
  localparam logic [31:0] OFS_RIS      = 32'h14;
  localparam logic [31:0] OFS_MIS      = 32'h18;

  localparam int CTRL_W       = 3;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

endpackage

// File: rtl/apb3_timer_prescaler.sv
// Prescaler for the APB3 timer.
// Counts 0..prescale while enabled and emits a one-cycle tick in the cycle
// the count equals prescale, then wraps to 0.
//   gclk     : clock
//   grst_n   : synchronous active-low reset
//   en       : counting enable (timer EN bit)
//   clr      : force the count back to 0 on the next edge
//   prescale : terminal count
//   tick     : combinational tick, qualified by en
module apb3_timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      gclk,
  input  logic                      grst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] cnt;

  assign tick = en & (cnt == prescale);

  // Disabled holds at 0, so a later enable always starts a full prescale period.
  always_ff @(posedge gclk) begin
    if (!grst_n)                cnt <= '0;
    else if (clr || !en || tick) cnt <= '0;
    else                        cnt <= cnt + ONE;
  end

endmodule

// File: rtl/apb3_timer.sv
// APB3 32-bit down-counting timer with prescaler, periodic / one-shot modes
// and a level interrupt. Zero wait states.
//   HCLK, HRESETN : clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA : APB3 request
//   PRDATA, PREADY, PSLVERR              : APB3 response (PRDATA combinational)
//   TIMINT : RIS & IE, active-high level
module apb3_timer
  import apb3_timer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 5,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  TIMINT
);

  logic [31:0]               load_r, value_r;
  logic [CTRL_W-1:0]         ctrl_r;
  logic [PRESCALE_WIDTH-1:0] prescale_r;
  logic                      ris_r;

  // ---- decode ----
  logic [31:0] addr;
  logic sel_load, sel_value, sel_ctrl, sel_pre, sel_intclr, sel_ris, sel_mis;
  logic mapped, bad, access, wr;

  assign addr       = 32'(PADDR) & 32'hFFFF_FFFC;
  assign sel_load   = (addr == OFS_LOAD);
  assign sel_value  = (addr == OFS_VALUE);
  assign sel_ctrl   = (addr == OFS_CTRL);
  assign sel_pre    = (addr == OFS_PRESCALE);
  assign sel_intclr = (addr == OFS_INTCLR);
  assign sel_ris    = (addr == OFS_RIS);
  assign sel_mis    = (addr == OFS_MIS);
  assign mapped     = sel_load | sel_value | sel_ctrl | sel_pre | sel_intclr | sel_ris | sel_mis;

  assign bad = !mapped
             | (PWRITE  & (sel_value | sel_ris | sel_mis))
             | (!PWRITE & sel_intclr);

  assign access  = PSEL & PENABLE;
  assign wr      = access & PWRITE & !bad;
  assign PSLVERR = access & bad;
  assign PREADY  = 1'b1;

  logic load_wr, ctrl_wr, pre_wr, intclr_wr, ctrl_off;
  assign load_wr   = wr & sel_load;
  assign ctrl_wr   = wr & sel_ctrl;
  assign pre_wr    = wr & sel_pre;
  assign intclr_wr = wr & sel_intclr;
  // A CTRL write clearing EN discards any tick in the same cycle.
  assign ctrl_off  = ctrl_wr & !PWDATA[CTRL_EN];

  // ---- prescaler / expiry ----
  logic tick, tick_eff, expire;

  apb3_timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_pre (
    .gclk     (HCLK),
    .grst_n   (HRESETN),
    .en       (ctrl_r[CTRL_EN]),
    .clr      (load_wr | ctrl_off),
    .prescale (prescale_r),
    .tick     (tick)
  );

  assign tick_eff = tick & !ctrl_off;
  assign expire   = tick_eff & (value_r == '0);

  // ---- registers ----
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      load_r     <= '0;
      value_r    <= '0;
      ctrl_r     <= '0;
      prescale_r <= '0;
      ris_r      <= 1'b0;
    end else begin
      // LOAD write beats the count; expiry still raises RIS below.
      if (load_wr) begin
        load_r  <= PWDATA;
        value_r <= PWDATA;
      end else if (tick_eff) begin
        if (value_r != '0)             value_r <= value_r - 32'd1;
        else if (!ctrl_r[CTRL_ONESHOT]) value_r <= load_r;
      end

      if (ctrl_wr)                           ctrl_r <= PWDATA[CTRL_W-1:0];
      else if (expire && ctrl_r[CTRL_ONESHOT]) ctrl_r[CTRL_EN] <= 1'b0;

      if (pre_wr) prescale_r <= PWDATA[PRESCALE_WIDTH-1:0];

      // Set has priority over clear.
      if (expire)         ris_r <= 1'b1;
      else if (intclr_wr) ris_r <= 1'b0;
    end
  end

  assign TIMINT = ris_r & ctrl_r[CTRL_IE];

  // ---- read mux ----
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (sel_load)       PRDATA = load_r;
      else if (sel_value) PRDATA = value_r;
      else if (sel_ctrl)  PRDATA = 32'(ctrl_r);
      else if (sel_pre)   PRDATA = 32'(prescale_r);
      else if (sel_ris)   PRDATA = 32'(ris_r);
      else if (sel_mis)   PRDATA = 32'(TIMINT);
    end
  end

endmodule
